// File: rtl/main_processor_pkg.sv
// main_processor_pkg: shared ISA constants, ALU op enum and the fixed boot program ROM contents.
package main_processor_pkg;
   localparam int XLEN_DEF = 32;
   localparam int NUM_REGS_DEF = 32;
   localparam logic [6:0] OP_R = 7'b0110011;
   localparam logic [6:0] OP_I = 7'b0010011;
   localparam logic [2:0] F3_ADD = 3'b000;
   localparam logic [2:0] F3_SLL = 3'b001;
   localparam logic [2:0] F3_SLT = 3'b010;
   localparam logic [2:0] F3_SLTU = 3'b011;
   localparam logic [2:0] F3_XOR = 3'b100;
   localparam logic [2:0] F3_SRL = 3'b101;
   localparam logic [2:0] F3_OR = 3'b110;
   localparam logic [2:0] F3_AND = 3'b111;
   localparam logic [6:0] F7_BASE = 7'b0000000;
   localparam logic [6:0] F7_SUB = 7'b0100000;
   localparam logic [31:0] NOP = 32'h00000013;

   typedef enum logic [2:0] {
      ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLL, ALU_SRL, ALU_SLT
   } alu_op_t;

   function automatic logic [31:0] rom_word(input logic [4:0] i);
      case (i)
         5'd0: return {F7_BASE, 5'd2, 5'd1, F3_ADD, 5'd10, OP_R};
         5'd1: return {F7_SUB, 5'd1, 5'd10, F3_ADD, 5'd11, OP_R};
         5'd2: return {F7_BASE, 5'd11, 5'd10, F3_AND, 5'd12, OP_R};
         5'd3: return {12'hFFB, 5'd12, F3_ADD, 5'd13, OP_I};
         5'd4: return {F7_BASE, 5'd0, 5'd13, F3_SLT, 5'd14, OP_R};
         5'd5: return {F7_BASE, 5'd1, 5'd1, F3_ADD, 5'd0, OP_R};
         default: return NOP;
      endcase
   endfunction
endpackage

// File: rtl/main_processor_regfile.sv
// main_processor_regfile: 2 async read / 1 sync write register file; x[i]=i on reset, x0 reads 0,
// reads see a same-cycle write to the same register.
module main_processor_regfile
   import main_processor_pkg::*;
#(
   parameter int XLEN = XLEN_DEF,
   parameter int NUM_REGS = NUM_REGS_DEF,
   localparam int AW = $clog2(NUM_REGS)
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [AW-1:0]   ra1,
   input  logic [AW-1:0]   ra2,
   input  logic [AW-1:0]   wa,
   input  logic            we,
   input  logic [XLEN-1:0] wd,
   output logic [XLEN-1:0] rd1,
   output logic [XLEN-1:0] rd2
);
   logic [XLEN-1:0] regs [NUM_REGS];

   always_ff @(posedge clk or posedge reset)
      if (reset)
         for (int i = 0; i < NUM_REGS; i++) regs[i] <= XLEN'(i);
      else if (we && wa != '0)
         regs[wa] <= wd;

   always_comb begin
      rd1 = ra1 == '0 ? '0 : (we && wa == ra1) ? wd : regs[ra1];
      rd2 = ra2 == '0 ? '0 : (we && wa == ra2) ? wd : regs[ra2];
   end
endmodule

// File: rtl/main_processor.sv
// main_processor: 4-stage IF/ID/EX/WB RV32I-subset core with internal ROM and register file.
// Define DEBUG_PORTS_EN to expose dbg_pc and the WB-stage write (dbg_wb_we/rd/data) as outputs.
module main_processor
   import main_processor_pkg::*;
#(
   parameter int XLEN = XLEN_DEF,
   parameter int NUM_REGS = NUM_REGS_DEF,
   parameter int IMEM_DEPTH = 32
) (
   input  logic            clk,
   input  logic            reset
`ifdef DEBUG_PORTS_EN
   ,
   output logic [31:0]     dbg_pc,
   output logic            dbg_wb_we,
   output logic [4:0]      dbg_wb_rd,
   output logic [XLEN-1:0] dbg_wb_data
`endif
);
   localparam logic [31:0] PC_END = 32'(4 * IMEM_DEPTH);

   logic [31:0] pc;
   logic if_valid;
   logic [31:0] if_instr;
   logic ex_valid, ex_we, ex_use_imm;
   logic [4:0] ex_rd, ex_rs1, ex_rs2;
   logic [XLEN-1:0] ex_a, ex_b, ex_imm;
   alu_op_t ex_op;
   logic wb_valid, wb_we;
   logic [4:0] wb_rd;
   logic [XLEN-1:0] wb_data;

   logic [6:0] opc, f7;
   logic [2:0] f3;
   logic r_ok, i_ok, dec_we, wb_write, fwd_a, fwd_b;
   alu_op_t dec_op;
   logic [XLEN-1:0] rs1_val, rs2_val, dec_imm, alu_a, alu_b, alu_y;

   always_comb begin
      opc = if_instr[6:0];
      f3 = if_instr[14:12];
      f7 = if_instr[31:25];
      r_ok = opc == OP_R && f3 != F3_SLTU && (f7 == F7_BASE || (f7 == F7_SUB && f3 == F3_ADD));
      i_ok = opc == OP_I && (f3 == F3_ADD || f3 == F3_XOR || f3 == F3_OR || f3 == F3_AND);
      dec_we = if_valid && (r_ok || i_ok);
      dec_imm = {{(XLEN-12){if_instr[31]}}, if_instr[31:20]};
      dec_op = f3 == F3_ADD ? ((r_ok && f7[5]) ? ALU_SUB : ALU_ADD) :
               f3 == F3_AND ? ALU_AND : f3 == F3_OR ? ALU_OR : f3 == F3_XOR ? ALU_XOR :
               f3 == F3_SLL ? ALU_SLL : f3 == F3_SRL ? ALU_SRL : ALU_SLT;
   end

   assign wb_write = wb_valid && wb_we;

   main_processor_regfile #(.XLEN(XLEN), .NUM_REGS(NUM_REGS)) u_rf (
      .clk(clk), .reset(reset),
      .ra1(if_instr[19:15]), .ra2(if_instr[24:20]),
      .wa(wb_rd), .we(wb_write), .wd(wb_data),
      .rd1(rs1_val), .rd2(rs2_val)
   );

   // Distance-1 dependence: the instruction ahead sits in EX/WB, not yet in the register file.
   always_comb begin
      fwd_a = wb_write && wb_rd != '0 && wb_rd == ex_rs1;
      fwd_b = wb_write && wb_rd != '0 && wb_rd == ex_rs2;
      alu_a = fwd_a ? wb_data : ex_a;
      alu_b = ex_use_imm ? ex_imm : fwd_b ? wb_data : ex_b;
      alu_y = ex_op == ALU_SUB ? alu_a - alu_b :
              ex_op == ALU_AND ? alu_a & alu_b :
              ex_op == ALU_OR  ? alu_a | alu_b :
              ex_op == ALU_XOR ? alu_a ^ alu_b :
              ex_op == ALU_SLL ? alu_a << alu_b[4:0] :
              ex_op == ALU_SRL ? alu_a >> alu_b[4:0] :
              ex_op == ALU_SLT ? XLEN'($signed(alu_a) < $signed(alu_b)) : alu_a + alu_b;
   end

   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         pc <= '0;
         if_valid <= 1'b0;
         if_instr <= '0;
         ex_valid <= 1'b0;
         ex_we <= 1'b0;
         ex_use_imm <= 1'b0;
         ex_rd <= '0;
         ex_rs1 <= '0;
         ex_rs2 <= '0;
         ex_a <= '0;
         ex_b <= '0;
         ex_imm <= '0;
         ex_op <= ALU_ADD;
         wb_valid <= 1'b0;
         wb_we <= 1'b0;
         wb_rd <= '0;
         wb_data <= '0;
      end else begin
         pc <= pc + 32'd4 == PC_END ? '0 : pc + 32'd4;
         if_valid <= 1'b1;
         if_instr <= rom_word(pc[6:2]);
         ex_valid <= if_valid;
         ex_we <= dec_we;
         ex_use_imm <= i_ok;
         ex_rd <= if_instr[11:7];
         ex_rs1 <= if_instr[19:15];
         ex_rs2 <= if_instr[24:20];
         ex_a <= rs1_val;
         ex_b <= rs2_val;
         ex_imm <= dec_imm;
         ex_op <= dec_op;
         wb_valid <= ex_valid;
         wb_we <= ex_valid && ex_we;
         wb_rd <= ex_rd;
         wb_data <= alu_y;
      end

`ifdef DEBUG_PORTS_EN
   assign dbg_pc = pc;
   assign dbg_wb_we = wb_write;
   assign dbg_wb_rd = wb_rd;
   assign dbg_wb_data = wb_data;
`endif
endmodule

// File: tb/tb_main_processor.sv
// tb_main_processor: directed checks of the fixed program, forwarding, PC wrap and async reset.
module tb_main_processor;
   logic clk = 1'b0;
   logic reset = 1'b0;
   int vectors = 0;
   int miscompares = 0;
`ifdef DEBUG_PORTS_EN
   logic [31:0] dbg_pc, dbg_wb_data;
   logic dbg_wb_we;
   logic [4:0] dbg_wb_rd;
`endif

   always #5 clk = ~clk;

   main_processor dut (
      .clk(clk),
      .reset(reset)
`ifdef DEBUG_PORTS_EN
      ,
      .dbg_pc(dbg_pc),
      .dbg_wb_we(dbg_wb_we),
      .dbg_wb_rd(dbg_wb_rd),
      .dbg_wb_data(dbg_wb_data)
`endif
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      #1 reset = 1'b1;
      #1;
      for (int c = 0; c < 4; c++) begin
         if (c > 0) tick();
         vectors++;
         if (dut.pc !== 32'd0) begin
            miscompares++;
            $display("FAIL reset c=%0d pc got %h want 0", c, dut.pc);
         end
         vectors++;
         if ({dut.if_valid, dut.ex_valid, dut.wb_valid, dut.wb_we} !== 4'b0) begin
            miscompares++;
            $display("FAIL reset c=%0d valids got %b want 0000", c,
                     {dut.if_valid, dut.ex_valid, dut.wb_valid, dut.wb_we});
         end
         for (int r = 0; r < 32; r++) begin
            vectors++;
            if (dut.u_rf.regs[r] !== 32'(r)) begin
               miscompares++;
               $display("FAIL reset c=%0d x%0d got %h want %h", c, r, dut.u_rf.regs[r], 32'(r));
            end
         end
      end
   endtask

   task automatic test_program;
      logic [31:0] fin [5] = '{32'd3, 32'd2, 32'd2, 32'hFFFFFFFD, 32'd1};
      logic [31:0] want;
      @(negedge clk) reset = 1'b0;
      for (int e = 1; e <= 9; e++) begin
         tick();
         vectors++;
         if (dut.pc !== 32'(4 * e)) begin
            miscompares++;
            $display("FAIL prog_pc e=%0d got %h want %h", e, dut.pc, 32'(4 * e));
         end
         for (int r = 10; r <= 14; r++) begin
            want = (e >= r - 6) ? fin[r - 10] : 32'(r);
            vectors++;
            if (dut.u_rf.regs[r] !== want) begin
               miscompares++;
               $display("FAIL prog e=%0d x%0d got %h want %h", e, r, dut.u_rf.regs[r], want);
            end
         end
         vectors++;
         if (dut.u_rf.regs[0] !== 32'd0 || dut.u_rf.regs[1] !== 32'd1) begin
            miscompares++;
            $display("FAIL prog_x0x1 e=%0d got %h/%h want 0/1", e, dut.u_rf.regs[0], dut.u_rf.regs[1]);
         end
         if (e == 8) begin
            vectors++;
            if (dut.wb_valid !== 1'b1 || dut.wb_we !== 1'b1 || dut.wb_rd !== 5'd0) begin
               miscompares++;
               $display("FAIL prog_wb_x0 got v=%b we=%b rd=%0d want 1/1/0", dut.wb_valid, dut.wb_we, dut.wb_rd);
            end
         end
      end
   endtask

   task automatic test_pc_wrap;
      logic [31:0] fin [5] = '{32'd3, 32'd2, 32'd2, 32'hFFFFFFFD, 32'd1};
      logic [31:0] want;
      for (int e = 10; e <= 40; e++) begin
         tick();
         vectors++;
         if (dut.pc !== 32'((4 * e) % 128)) begin
            miscompares++;
            $display("FAIL wrap_pc e=%0d got %h want %h", e, dut.pc, 32'((4 * e) % 128));
         end
      end
      for (int r = 0; r < 32; r++) begin
         want = (r >= 10 && r <= 14) ? fin[r - 10] : 32'(r);
         vectors++;
         if (dut.u_rf.regs[r] !== want) begin
            miscompares++;
            $display("FAIL wrap_nop x%0d got %h want %h", r, dut.u_rf.regs[r], want);
         end
      end
   endtask

   task automatic test_async_reset;
      reset = 1'b1;
      tick();
      @(negedge clk) reset = 1'b0;
      repeat (5) tick();
      vectors++;
      if (dut.u_rf.regs[10] !== 32'd3 || dut.u_rf.regs[11] !== 32'd2) begin
         miscompares++;
         $display("FAIL arst_pre got x10=%h x11=%h want 3/2", dut.u_rf.regs[10], dut.u_rf.regs[11]);
      end
      #2 reset = 1'b1;
      #1;
      vectors++;
      if (dut.pc !== 32'd0 || dut.u_rf.regs[10] !== 32'd10 || dut.u_rf.regs[11] !== 32'd11) begin
         miscompares++;
         $display("FAIL arst_now got pc=%h x10=%h x11=%h want 0/a/b", dut.pc, dut.u_rf.regs[10], dut.u_rf.regs[11]);
      end
      for (int c = 0; c < 2; c++) begin
         tick();
         vectors++;
         if (dut.pc !== 32'd0 || {dut.if_valid, dut.ex_valid, dut.wb_valid} !== 3'b0) begin
            miscompares++;
            $display("FAIL arst_hold c=%0d got pc=%h valids=%b want 0/000", c, dut.pc,
                     {dut.if_valid, dut.ex_valid, dut.wb_valid});
         end
      end
      @(negedge clk) reset = 1'b0;
      for (int e = 1; e <= 4; e++) begin
         tick();
         vectors++;
         if (dut.u_rf.regs[10] !== (e >= 4 ? 32'd3 : 32'd10)) begin
            miscompares++;
            $display("FAIL arst_replay e=%0d x10 got %h want %h", e, dut.u_rf.regs[10], e >= 4 ? 32'd3 : 32'd10);
         end
      end
   endtask

   initial begin
      test_reset();
      test_program();
      test_pc_wrap();
      test_async_reset();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
